// File: rtl/inv_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// inv_mix_columns_seq
//
// Iterative AES InvMixColumns engine for the decryption round loop. A 128-bit
// state is captured through a valid/ready input port, transformed in place
// COLS_PER_CYCLE columns per clock, and presented on a valid/ready output port.
//
// Handshake: a transfer on either port happens on a rising clk edge where
// valid and ready are both high. The producer holds valid (and data) until
// that edge. in_ready and out_valid are never high together, so a result is
// fully drained before the next state is accepted.
//
// Parameters:
//   COLS_PER_CYCLE  columns transformed per clock; 1, 2 or 4
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_state is valid
//   in_ready   engine can accept a state (registered)
//   in_state   input state; column c = in_state[127-32c -: 32],
//              row byte r of a column = bits [31-8r -: 8]
//   out_valid  out_state holds a finished result (registered)
//   out_ready  consumer accepts out_state
//   out_state  transformed state, same byte layout (registered)
//   busy       high while the engine is in BUSY (registered)
// -----------------------------------------------------------------------------
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    // Only widths that divide the four columns evenly are supported.
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $fatal(1, "inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Counter step and the counter value of the final BUSY cycle. With four
    // columns per cycle the step truncates to 0 and the only BUSY cycle is cnt=0.
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] cols [4];   // working register, cols[0] is the MSB column

    // -------------------------------------------------------------------------
    // GF(2^8) helpers
    // -------------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] o0, o1, o2, o3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        o0 = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
        o1 = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
        o2 = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
        o3 = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
        return {o0, o1, o2, o3};
    endfunction

    // -------------------------------------------------------------------------
    // Column lanes: lane k works on column cnt+k. Because cnt is always a
    // multiple of COLS_PER_CYCLE the lanes never wrap past column 3.
    // -------------------------------------------------------------------------
    logic [1:0]  col_idx [COLS_PER_CYCLE];
    logic [31:0] col_res [COLS_PER_CYCLE];

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
        assign col_idx[k] = cnt + 2'(k);
        assign col_res[k] = inv_mix_col(cols[col_idx[k]]);
    end

    // -------------------------------------------------------------------------
    // Control FSM and working register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                cols[c] <= 32'h0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int c = 0; c < 4; c++) begin
                            cols[c] <= in_state[127-32*c -: 32];
                        end
                        cnt      <= 2'd0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                        cols[col_idx[k]] <= col_res[k];
                    end
                    cnt <= cnt + CNT_STEP;
                    if (cnt == LAST_CNT) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Result is held until the consumer takes it; in_ready
                    // comes back only after out_valid has dropped.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 2'd0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_state = {cols[0], cols[1], cols[2], cols[3]};

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// tb_inv_mix_columns_seq
//
// Bench for inv_mix_columns_seq. Three instances (COLS_PER_CYCLE = 1, 2, 4)
// share clock and reset; each has its own handshake signals indexed by d.
// Expected results are pushed to exp_q when a state is driven and popped when
// the engine presents its output. Inputs change and outputs are sampled 1 ns
// after the rising edge. Latency is counted in rising edges with the
// accepting edge counted as the first.
// -----------------------------------------------------------------------------
module tb_inv_mix_columns_seq;

    localparam int N = 3;
    localparam logic [127:0] KNOWN_IN  = 128'h8e4da1bc_9fdc589d_4d7ebdf8_d5d5d7d6;
    localparam logic [127:0] KNOWN_OUT = 128'hdb135345_f20a225c_2d26314c_d4d4d4d5;
    localparam logic [127:0] FIXED     = 128'hc6c6c6c6_01010101_c6c6c6c6_01010101;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         iv   [N];
    logic         ir   [N];
    logic [127:0] ist  [N];
    logic         ov   [N];
    logic         ordy [N];
    logic [127:0] ost  [N];
    logic         bz   [N];

    int lat_req [N] = '{5, 3, 2};

    logic [127:0] exp_q [$];
    int errors = 0;
    int checks = 0;

    inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_state(ist[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(ost[0]),
        .busy(bz[0])
    );

    inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_state(ist[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(ost[1]),
        .busy(bz[1])
    );

    inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_state(ist[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(ost[2]),
        .busy(bz[2])
    );

    // ---------------- forward MixColumns model ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [127:0] mix_state(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one state and hold it through the accepting edge.
    task automatic send(input int d, input logic [127:0] s);
        int n;
        n = 0;
        while (ir[d] !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (ir[d] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut%0d: in_ready=%b required 1", d, ir[d]);
        end
        iv[d]  = 1'b1;
        ist[d] = s;
        step();
        iv[d]  = 1'b0;
    endtask

    // Wait (bounded) for out_valid; lat counts the accepting edge as 1.
    task automatic wait_valid(input int d, output int lat);
        lat = 1;
        while (ov[d] !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        for (int d = 0; d < N; d++) begin
            checks++;
            if (ov[d] !== 1'b0 || bz[d] !== 1'b0 || ost[d] !== 128'h0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: out_valid=%b busy=%b out_state=%h required 0 0 0",
                         d, ov[d], bz[d], ost[d]);
            end
        end
        rst_n = 1'b1;
        step();
        for (int d = 0; d < N; d++) begin
            checks++;
            if (ir[d] !== 1'b1 || ov[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release dut%0d: in_ready=%b out_valid=%b required 1 0",
                         d, ir[d], ov[d]);
            end
        end
    endtask

    task automatic test_vector(input int d, input logic [127:0] s_in, input logic [127:0] s_out,
                               input string name);
        int lat;
        logic [127:0] x;
        ordy[d] = 1'b1;
        exp_q.push_back(s_out);
        send(d, s_in);
        wait_valid(d, lat);
        checks++;
        if (lat != lat_req[d]) begin
            errors++;
            $display("FAIL %s_latency dut%0d: got %0d clocks required %0d", name, d, lat, lat_req[d]);
        end
        checks++;
        if (ov[d] !== 1'b1 || ir[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s_handshake dut%0d: out_valid=%b in_ready=%b required 1 0",
                     name, d, ov[d], ir[d]);
        end
        x = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        checks++;
        if (ost[d] !== x) begin
            errors++;
            $display("FAIL %s_data dut%0d: out_state=%h required %h", name, d, ost[d], x);
        end
        step();
        checks++;
        if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s_drain dut%0d: out_valid=%b in_ready=%b required 0 1",
                     name, d, ov[d], ir[d]);
        end
    endtask

    task automatic test_known();
        test_vector(0, KNOWN_IN, KNOWN_OUT, "known");
    endtask

    task automatic test_fixed();
        test_vector(0, FIXED, FIXED, "fixed");
    endtask

    task automatic test_sweep();
        test_vector(1, KNOWN_IN, KNOWN_OUT, "sweep");
        test_vector(2, KNOWN_IN, KNOWN_OUT, "sweep");
        test_vector(2, FIXED, FIXED, "sweep_fixed");
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] x;
        ordy[0] = 1'b0;
        exp_q.push_back(KNOWN_OUT);
        send(0, KNOWN_IN);
        wait_valid(0, lat);
        for (int i = 0; i < 10; i++) begin
            iv[0]  = 1'b1;
            ist[0] = {$urandom, $urandom, $urandom, $urandom};
            checks++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || bz[0] !== 1'b0 || ost[0] !== KNOWN_OUT) begin
                errors++;
                $display("FAIL backpressure_hold cycle %0d: out_valid=%b in_ready=%b busy=%b out_state=%h required 1 0 0 %h",
                         i, ov[0], ir[0], bz[0], ost[0], KNOWN_OUT);
            end
            step();
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        x = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        checks++;
        if (ov[0] !== 1'b1 || ost[0] !== x) begin
            errors++;
            $display("FAIL backpressure_accept: out_valid=%b out_state=%h required 1 %h", ov[0], ost[0], x);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || ir[0] !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_after cycle %0d: out_valid=%b busy=%b in_ready=%b required 0 0 1",
                         i, ov[0], bz[0], ir[0]);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        ordy[0] = 1'b1;
        send(0, KNOWN_IN);      // accepting edge done, cnt=0
        step();                 // cnt=1
        step();                 // cnt=2
        checks++;
        if (bz[0] !== 1'b1) begin
            errors++;
            $display("FAIL areset_busy_before: busy=%b required 1", bz[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || bz[0] !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: out_valid=%b busy=%b required 0 0", ov[0], bz[0]);
        end
        #3;
        rst_n = 1'b1;
        step();
        checks++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL areset_release: in_ready=%b out_valid=%b required 1 0", ir[0], ov[0]);
        end
        test_vector(0, KNOWN_IN, KNOWN_OUT, "areset_next");
    endtask

    task automatic test_back_to_back();
        int sent, cyc, last_rise;
        logic prev_ov;
        logic [127:0] s, x;
        sent = 0;
        cyc = 0;
        last_rise = -1;
        prev_ov = 1'b0;
        ordy[0] = 1'b1;
        while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
            if (ov[0] === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected cycle %0d: out_state=%h", cyc, ost[0]);
                end else begin
                    x = exp_q.pop_front();
                    if (ost[0] !== x) begin
                        errors++;
                        $display("FAIL b2b_data cycle %0d: out_state=%h required %h", cyc, ost[0], x);
                    end
                end
                if (!prev_ov) begin
                    if (last_rise >= 0) begin
                        checks++;
                        if (cyc - last_rise != 6) begin
                            errors++;
                            $display("FAIL b2b_period cycle %0d: got %0d clocks required 6",
                                     cyc, cyc - last_rise);
                        end
                    end
                    last_rise = cyc;
                end
            end
            prev_ov = ov[0];
            if (ir[0] === 1'b1 && sent < 1000) begin
                s = {$urandom, $urandom, $urandom, $urandom};
                exp_q.push_back(s);
                ist[0] = mix_state(s);
                iv[0]  = 1'b1;
                sent++;
            end else begin
                iv[0] = 1'b0;
            end
            step();
            cyc++;
        end
        iv[0] = 1'b0;
        checks++;
        if (sent != 1000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_complete: sent=%0d pending=%0d required 1000 0", sent, exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int d = 0; d < N; d++) begin
            iv[d]   = 1'b0;
            ist[d]  = '0;
            ordy[d] = 1'b0;
        end
        test_reset();
        test_known();
        test_fixed();
        test_sweep();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
